// File: rtl/cdb_pkg.sv
// Shared CDB definitions: bus field widths, the broadcast entry layout and the
// module_select bit positions that instantiators use to pick each unit's grant.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF_LEN
`define PRF_LEN 6
`endif
`ifndef ROB_LEN
`define ROB_LEN 5
`endif

package cdb_pkg;

    typedef struct packed {
        logic [`XLEN-1:0]    value;
        logic [`PRF_LEN-1:0] prf_idx;
        logic [`ROB_LEN-1:0] rob_idx;
        logic [`XLEN-1:0]    PC;
    } cdb_entry_t;

    // Bit positions within the arbiter's module_select vector.
    typedef enum int unsigned {
        CDB_SEL_BR  = 0,
        CDB_SEL_MEM = 1,
        CDB_SEL_MUL = 2,
        CDB_SEL_ALU = 3
    } cdb_sel_e;

    localparam int CDB_SEL_W = 4;

endpackage

// File: rtl/fu_cdb_queue.sv
// Per-FU completion queue: buffers finished results in order and offers the
// oldest one to the CDB arbiter, stalling the FU instead of dropping results.
module fu_cdb_queue
    import cdb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic                fu_valid,
    input  logic [`XLEN-1:0]    fu_value,
    input  logic [`PRF_LEN-1:0] fu_prf_idx,
    input  logic [`ROB_LEN-1:0] fu_rob_idx,
    input  logic [`XLEN-1:0]    fu_PC,
    output logic                fu_stall,
    input  logic                cdb_gnt,
    output logic                cdb_req_valid,
    output logic [`XLEN-1:0]    cdb_req_value,
    output logic [`PRF_LEN-1:0] cdb_req_prf_idx,
    output logic [`ROB_LEN-1:0] cdb_req_rob_idx,
    output logic [`XLEN-1:0]    cdb_req_PC,
    output logic                overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       entries [DEPTH];
    cdb_entry_t       head_entry;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    // Stall is purely from registered occupancy; a same-cycle grant does not free a slot.
    assign full          = (count == CNT_W'(DEPTH));
    assign fu_stall      = full;
    assign cdb_req_valid = (count != '0);

    // squash overrides everything in its cycle, including a late FU result.
    assign push = fu_valid && !full && !squash;
    assign pop  = cdb_req_valid && cdb_gnt && !squash;

    assign head_entry      = entries[head_ptr];
    assign cdb_req_value   = head_entry.value;
    assign cdb_req_prf_idx = head_entry.prf_idx;
    assign cdb_req_rob_idx = head_entry.rob_idx;
    assign cdb_req_PC      = head_entry.PC;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (fu_valid && full && !squash) begin
                overflow_err <= 1'b1;
            end
            if (squash) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                if (pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Payload is never reset; only the pointers decide which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[tail_ptr] <= '{value:   fu_value,
                                   prf_idx: fu_prf_idx,
                                   rob_idx: fu_rob_idx,
                                   PC:      fu_PC};
        end
    end

endmodule

// File: tb/tb_fu_cdb_queue.sv
// Directed bench for fu_cdb_queue with hand-computed expectations.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF_LEN
`define PRF_LEN 6
`endif
`ifndef ROB_LEN
`define ROB_LEN 5
`endif

module tb_fu_cdb_queue;

    logic                clock;
    logic                reset;
    logic                squash;
    logic                fu_valid;
    logic [`XLEN-1:0]    fu_value;
    logic [`PRF_LEN-1:0] fu_prf_idx;
    logic [`ROB_LEN-1:0] fu_rob_idx;
    logic [`XLEN-1:0]    fu_PC;
    logic                fu_stall;
    logic                cdb_gnt;
    logic                cdb_req_valid;
    logic [`XLEN-1:0]    cdb_req_value;
    logic [`PRF_LEN-1:0] cdb_req_prf_idx;
    logic [`ROB_LEN-1:0] cdb_req_rob_idx;
    logic [`XLEN-1:0]    cdb_req_PC;
    logic                overflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    fu_cdb_queue #(.DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (fu_valid),
        .fu_value        (fu_value),
        .fu_prf_idx      (fu_prf_idx),
        .fu_rob_idx      (fu_rob_idx),
        .fu_PC           (fu_PC),
        .fu_stall        (fu_stall),
        .cdb_gnt         (cdb_gnt),
        .cdb_req_valid   (cdb_req_valid),
        .cdb_req_value   (cdb_req_value),
        .cdb_req_prf_idx (cdb_req_prf_idx),
        .cdb_req_rob_idx (cdb_req_rob_idx),
        .cdb_req_PC      (cdb_req_PC),
        .overflow_err    (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [31:0] v);
        fu_valid = 1'b1;
        fu_value = v;
        step();
        fu_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        squash     = 1'b0;
        fu_valid   = 1'b0;
        fu_value   = '0;
        fu_prf_idx = '0;
        fu_rob_idx = '0;
        fu_PC      = '0;
        cdb_gnt    = 1'b0;
        #2;
        check("rst_valid", cdb_req_valid, 0);
        check("rst_stall", fu_stall, 0);
        check("rst_ovf", overflow_err, 0);
        step();
        reset = 1'b0;
        step();

        // Single push, held until granted.
        fu_valid = 1'b1; fu_value = 32'h11; fu_prf_idx = 5; fu_rob_idx = 3; fu_PC = 32'h100;
        #1;
        check("no_bypass", cdb_req_valid, 0);
        step();
        fu_valid = 1'b0;
        check("t1_valid", cdb_req_valid, 1);
        check("t1_value", cdb_req_value, 32'h11);
        check("t1_prf", cdb_req_prf_idx, 5);
        check("t1_rob", cdb_req_rob_idx, 3);
        check("t1_pc", cdb_req_PC, 32'h100);
        step();
        check("t1_hold_valid", cdb_req_valid, 1);
        check("t1_hold_value", cdb_req_value, 32'h11);
        cdb_gnt = 1'b1;
        step();
        cdb_gnt = 1'b0;
        check("t1_popped", cdb_req_valid, 0);

        // Fill to full, overflow, drain in order.
        for (int i = 1; i <= 4; i++) begin
            push_one(i);
            check($sformatf("fill_stall_%0d", i), fu_stall, (i == 4) ? 1 : 0);
        end
        push_one(5);
        check("ovf_set", overflow_err, 1);
        check("ovf_still_full", fu_stall, 1);
        cdb_gnt = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_valid_%0d", i), cdb_req_valid, 1);
            check($sformatf("drain_value_%0d", i), cdb_req_value, i);
            step();
            check($sformatf("drain_stall_%0d", i), fu_stall, 0);
        end
        cdb_gnt = 1'b0;
        check("drain_empty", cdb_req_valid, 0);
        check("ovf_sticky", overflow_err, 1);

        // Streaming: push and pop every cycle, occupancy stays at one.
        fu_valid = 1'b1;
        cdb_gnt  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fu_value = i;
            if (i > 0) begin
                check($sformatf("stream_valid_%0d", i), cdb_req_valid, 1);
                check($sformatf("stream_value_%0d", i - 1), cdb_req_value, i - 1);
                check($sformatf("stream_stall_%0d", i), fu_stall, 0);
            end
            step();
        end
        fu_valid = 1'b0;
        check("stream_last", cdb_req_value, 19);
        step();
        cdb_gnt = 1'b0;
        check("stream_empty", cdb_req_valid, 0);

        // Squash with concurrent push and grant.
        push_one(32'h21);
        push_one(32'h22);
        push_one(32'h23);
        squash = 1'b1; fu_valid = 1'b1; fu_value = 32'h99; cdb_gnt = 1'b1;
        step();
        squash = 1'b0; fu_valid = 1'b0; cdb_gnt = 1'b0;
        check("sq_valid", cdb_req_valid, 0);
        check("sq_stall", fu_stall, 0);
        check("sq_ovf_kept", overflow_err, 1);
        push_one(32'hAA);
        check("sq_next_valid", cdb_req_valid, 1);
        check("sq_next_value", cdb_req_value, 32'hAA);
        cdb_gnt = 1'b1;
        step();
        cdb_gnt = 1'b0;
        check("sq_next_sole", cdb_req_valid, 0);

        // Asynchronous reset between edges with a full queue.
        for (int i = 0; i < 4; i++) push_one(32'h31 + i);
        check("ar_full", fu_stall, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", cdb_req_valid, 0);
        check("ar_stall", fu_stall, 0);
        check("ar_ovf", overflow_err, 0);
        #1;
        reset = 1'b0;
        step();
        check("ar_after_valid", cdb_req_valid, 0);

        // Grant while empty is ignored.
        cdb_gnt = 1'b1;
        step();
        step();
        cdb_gnt = 1'b0;
        check("eg_valid", cdb_req_valid, 0);
        check("eg_stall", fu_stall, 0);
        push_one(32'h7);
        check("eg_push_valid", cdb_req_valid, 1);
        check("eg_push_value", cdb_req_value, 32'h7);
        step();
        check("eg_push_hold", cdb_req_value, 32'h7);
        cdb_gnt = 1'b1;
        step();
        cdb_gnt = 1'b0;
        check("eg_popped", cdb_req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
